sdp_ram: RTL

Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock.
- Write side has per-byte enables.
- Read is registered with a valid pulse.
- Read/write collision policy is selectable.
- An optional post-reset clear sweep zeroes the array.
- Drop-in storage for FIFOs, line buffers and register files wherever the 64x8 single-port RAM is too narrow or too small.

---
 rtl/ram_pkg.sv | 16 +
 rtl/sdp_ram_core.sv | 33 +++
 rtl/sdp_ram.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared constants, FSM state type and width helper for the sdp_ram block.
package ram_pkg;

   localparam int RD_FIRST = 0;
   localparam int WR_FIRST = 1;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } state_t;

   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Bare simple-dual-port array: byte-enabled write port, registered read port.
module sdp_ram_core
   import ram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 2 ** ADDR_W
) (
   input  logic                          i_clk,
   input  logic                          i_we,
   input  logic [ADDR_W-1:0]             i_waddr,
   input  logic [DATA_W-1:0]             i_wdata,
   input  logic [be_width(DATA_W)-1:0]   i_wbe,
   input  logic                          i_re,
   input  logic [ADDR_W-1:0]             i_raddr,
   output logic [DATA_W-1:0]             o_rdata
);

   localparam int BE_W = be_width(DATA_W);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array and its read register carry no reset so the storage maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int k = 0; k < BE_W; k++) begin
            if (i_wbe[k]) mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
         end
      end
      if (i_re) o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/sdp_ram.sv
// Simple-dual-port RAM wrapper: clear sweep, range check, collision bypass, valid pipeline.
// Optional second output register stage enabled by defining SDP_RAM_OUTREG_EN.
module sdp_ram
   import ram_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 6,
   parameter int DEPTH          = 2 ** ADDR_W,
   parameter int RD_MODE        = RD_FIRST,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   output logic                          o_ready,
   input  logic                          i_we,
   input  logic [ADDR_W-1:0]             i_waddr,
   input  logic [DATA_W-1:0]             i_wdata,
   input  logic [be_width(DATA_W)-1:0]   i_wbe,
   input  logic                          i_re,
   input  logic [ADDR_W-1:0]             i_raddr,
   output logic [DATA_W-1:0]             o_rdata,
   output logic                          o_rvalid
);

   localparam int BE_W = be_width(DATA_W);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic              ready_q;
   logic              clr_last;

   logic              w_ok, r_ok, wr_fire, rd_fire;
   logic              core_we, core_re;
   logic [ADDR_W-1:0] core_waddr;
   logic [DATA_W-1:0] core_wdata, core_rdata;
   logic [BE_W-1:0]   core_wbe;

   logic              rvalid1, zero_q, byp_q;
   logic [DATA_W-1:0] byp_wdata_q, rdata1;
   logic [BE_W-1:0]   byp_wbe_q;

   assign clr_last = (clr_addr == ADDR_W'(DEPTH - 1));

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (i_reset) begin
         state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_addr <= '0;
         ready_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_q  <= (state_nxt == ST_RUN);
         if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   assign o_ready = ready_q;

   // Addresses beyond DEPTH never reach the array.
   assign w_ok    = ({1'b0, i_waddr} < (ADDR_W + 1)'(DEPTH));
   assign r_ok    = ({1'b0, i_raddr} < (ADDR_W + 1)'(DEPTH));
   assign wr_fire = ready_q && !i_reset && i_we && w_ok;
   assign rd_fire = ready_q && !i_reset && i_re;

   always_comb begin
      core_we    = wr_fire;
      core_waddr = i_waddr;
      core_wdata = i_wdata;
      core_wbe   = i_wbe;
      if (state == ST_CLEAR) begin
         core_we    = !i_reset;
         core_waddr = clr_addr;
         core_wdata = '0;
         core_wbe   = '1;
      end
   end

   assign core_re = rd_fire && r_ok;

   sdp_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_core (
      .i_clk   (i_clk),
      .i_we    (core_we),
      .i_waddr (core_waddr),
      .i_wdata (core_wdata),
      .i_wbe   (core_wbe),
      .i_re    (core_re),
      .i_raddr (i_raddr),
      .o_rdata (core_rdata)
   );

   // Issue-cycle bookkeeping; zero_q also supplies the post-reset all-zero output.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rvalid1 <= 1'b0;
         zero_q  <= 1'b1;
         byp_q   <= 1'b0;
      end else begin
         rvalid1 <= rd_fire;
         if (rd_fire) begin
            zero_q      <= !r_ok;
            byp_q       <= (RD_MODE == WR_FIRST) && wr_fire && (i_waddr == i_raddr);
            byp_wdata_q <= i_wdata;
            byp_wbe_q   <= i_wbe;
         end
      end
   end

   // The core returns the pre-write word; write-first overlays the enabled bytes.
   always_comb begin
      rdata1 = core_rdata;
      if (zero_q) begin
         rdata1 = '0;
      end else if (byp_q) begin
         for (int k = 0; k < BE_W; k++) begin
            if (byp_wbe_q[k]) rdata1[8*k +: 8] = byp_wdata_q[8*k +: 8];
         end
      end
   end

`ifdef SDP_RAM_OUTREG_EN
   logic [DATA_W-1:0] rdata2;
   logic              rvalid2;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rdata2  <= '0;
         rvalid2 <= 1'b0;
      end else begin
         rvalid2 <= rvalid1;
         if (rvalid1) rdata2 <= rdata1;
      end
   end

   assign o_rdata  = rdata2;
   assign o_rvalid = rvalid2;
`else
   assign o_rdata  = rdata1;
   assign o_rvalid = rvalid1;
`endif

endmodule
